// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit, one bit per clock.
// MUL/UMULH via shift-add, UDIV/SDIV via restoring shift-subtract.
module mul_div_unit #(
    parameter int WIDTH = 64,
    parameter int RW_W  = 5
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic [RW_W-1:0]  RdIn,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [RW_W-1:0]  RdOut,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_SDIV  = 2'b11;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [RW_W-1:0]  rd_q;
    logic             neg_q;

    // acc: product high half / partial remainder
    // lo:  multiplier shifting out, product low half / quotient shifting in
    // opb: multiplicand / divisor magnitude
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opb;

    logic             load;
    logic             div_zero;
    logic             is_sdiv;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_hi;
    logic [WIDTH-1:0] mul_acc_n;
    logic [WIDTH-1:0] mul_lo_n;

    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_tr;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc_n;
    logic [WIDTH-1:0] div_lo_n;

    logic [WIDTH-1:0] fix_val;

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

    // Request acceptance and operand conditioning at load time
    always_comb begin
        load     = 1'b0;
        div_zero = 1'b0;
        is_sdiv  = 1'b0;
        neg_a    = 1'b0;
        neg_b    = 1'b0;
        a_mag    = OperandA;
        b_mag    = OperandB;
        load     = (state == IDLE) && Start && !Abort;
        div_zero = Op[1] && (OperandB == '0);
        is_sdiv  = (Op == OP_SDIV);
        neg_a    = is_sdiv && OperandA[WIDTH-1];
        neg_b    = is_sdiv && OperandB[WIDTH-1];
        if (neg_a) begin
            a_mag = -OperandA;
        end
        if (neg_b) begin
            b_mag = -OperandB;
        end
    end

    // One iteration of shift-add and restoring shift-subtract
    always_comb begin
        mul_sum   = '0;
        mul_hi    = '0;
        mul_acc_n = '0;
        mul_lo_n  = '0;
        div_sh    = '0;
        div_tr    = '0;
        div_ge    = 1'b0;
        div_acc_n = '0;
        div_lo_n  = '0;

        mul_sum   = {1'b0, acc} + {1'b0, opb};
        mul_hi    = lo[0] ? mul_sum : {1'b0, acc};
        mul_acc_n = mul_hi[WIDTH:1];
        mul_lo_n  = {mul_hi[0], lo[WIDTH-1:1]};

        div_sh    = {acc, lo[WIDTH-1]};
        div_tr    = div_sh - {1'b0, opb};
        div_ge    = (div_sh >= {1'b0, opb});
        div_acc_n = div_ge ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_lo_n  = {lo[WIDTH-2:0], div_ge};
    end

    // Final result selection: product half or signed-corrected quotient
    always_comb begin
        fix_val = lo;
        unique case (op_q)
            OP_MUL:   fix_val = lo;
            OP_UMULH: fix_val = acc;
            OP_UDIV:  fix_val = lo;
            OP_SDIV:  fix_val = neg_q ? -lo : lo;
            default:  fix_val = lo;
        endcase
    end

    // Control FSM and iteration counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (Abort && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state <= div_zero ? DONE : RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX:     state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand latch and per-bit datapath update
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            neg_q <= 1'b0;
            acc   <= '0;
            lo    <= '0;
            opb   <= '0;
        end else if (load) begin
            op_q  <= Op;
            rd_q  <= RdIn;
            acc   <= '0;
            if (Op[1]) begin
                lo    <= a_mag;
                opb   <= b_mag;
                neg_q <= neg_a ^ neg_b;
            end else begin
                lo    <= OperandB;
                opb   <= OperandA;
                neg_q <= 1'b0;
            end
        end else if ((state == RUN) && !Abort) begin
            if (op_q[1]) begin
                acc <= div_acc_n;
                lo  <= div_lo_n;
            end else begin
                acc <= mul_acc_n;
                lo  <= mul_lo_n;
            end
        end
    end

    // Architectural outputs change only when an op completes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Result    <= '0;
            RdOut     <= '0;
            DivByZero <= 1'b0;
        end else if (load && div_zero) begin
            Result    <= '0;
            RdOut     <= RdIn;
            DivByZero <= 1'b1;
        end else if ((state == FIX) && !Abort) begin
            Result    <= fix_val;
            RdOut     <= rd_q;
            DivByZero <= 1'b0;
        end
    end

endmodule
